pc_redirect_ctrl: RTL and testbench
===================================

# pc_redirect_ctrl

Fetch-side consumer of the EX-stage branch resolution: owns the program counter, accepts the taken-branch/jump redirect (`PcSel`, `BrPC`) produced by the branch unit, and drives the instruction-memory fetch address. It arbitrates redirects against hazard stalls and instruction-memory back-pressure, buffers a redirect that arrives mid-fetch, squashes wrong-path instructions in IF/ID and ID/EX, and keeps redirect statistics and target-error flags.

## Interface
- `PC_W`, 9: PC width in bits; matches the branch unit's `Cur_PC` width.
- `RESET_PC`, 0: PC value loaded on reset (`PC_W` bits, word-aligned).
- `CNT_W`, 16: width of the redirect counter.

- `clk`  in  1  clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset (one clock; reset is asynchronous and active-low).
- `PcSel`  in  1  redirect request from the branch unit (1 = taken).
- `BrPC`  in  32  redirect target from the branch unit.
- `stall`  in  1  hazard-unit stall of IF/ID (load-use).
- `imem_ready`  in  1  instruction memory accepts/completes the current fetch this cycle.
- `Cur_PC`  out  `PC_W`  current fetch address, to imem and the IF/ID register.
- `fetch_valid`  out  1  fetch request valid.
- `flush_ifid`  out  1  squash IF/ID this cycle.
- `flush_idex`  out  1  squash ID/EX this cycle.
- `target_err`  out  1  sticky: a redirect target was misaligned or out of range.
- `redirect_cnt`  out  `CNT_W`  saturating count of applied redirects.

## Operation
- FSM states: BOOT, RUN, PEND.
- BOOT: entered on reset; `fetch_valid`=0 and PC holds `RESET_PC`. Transitions to RUN unconditionally on the first edge.
- RUN, `fetch_valid`=1:
  - Advance (`fire`): `imem_ready && !stall && !PcSel` → `PC <= PC + 4`, truncated to `PC_W` bits, so it wraps to 0 after `2^PC_W - 4`.
  - `stall && !PcSel`: PC holds, `fetch_valid` stays 1.
  - `PcSel && imem_ready`: `PC <= tgt`; `flush_ifid`=`flush_idex`=1 combinationally in the same cycle.
  - Redirect takes priority over `stall`.
  - `PcSel && !imem_ready`: the in-flight fetch address must not change. Latch `tgt` into the pending buffer, assert `flush_idex`=1 this cycle, and go to PEND.
- PEND: `Cur_PC` holds the old address and `fetch_valid`=1.
  - On `imem_ready`: `PC <= pending`, `flush_ifid`=1 this cycle (the returned instruction is wrong-path), then go to RUN.
  - `PcSel` in PEND is ignored, because EX was already squashed. `stall` in PEND is ignored.
- Target formation: `tgt = {BrPC[PC_W-1:2], 2'b00}`.
  - `target_err` is set (sticky until reset) when `BrPC[1:0] != 0` or `BrPC[31:PC_W] != 0`, evaluated when the redirect is accepted.
  - The redirect is still applied with the truncated, aligned target.
- `redirect_cnt` increments once per accepted `PcSel` (RUN only) and saturates at all-ones.
- Flush outputs are 0 in BOOT and whenever no redirect is in progress.

## Timing
- Reset values: `Cur_PC`=`RESET_PC`, `fetch_valid`=0, `flush_ifid`=0, `flush_idex`=0, `target_err`=0, `redirect_cnt`=0. Pending buffer is cleared and the state is BOOT.
- Reset asserted mid-operation (including in PEND) clears everything immediately; the pending redirect is discarded.
- First fetch (`fetch_valid`=1, `Cur_PC`=`RESET_PC`) occurs in the cycle after the first post-reset edge.
- Redirect latency:
  - From `PcSel` high with `imem_ready`: `Cur_PC`=`tgt` one cycle later.
  - Via PEND: `Cur_PC`=`tgt` in the cycle after `imem_ready` arrives.
- `flush_*` are combinational from the current state and inputs. `Cur_PC`, `fetch_valid`, `target_err` and `redirect_cnt` are registered.
- `PcSel` and `stall` together in RUN: the redirect wins, no stall hold occurs, and both flushes are asserted.

## Structure
- Package `pc_redirect_pkg`: state enum `redir_state_e` {BOOT, RUN, PEND} and the `PC_INCR` = 4 constant.
- Sub-module `sat_counter` (parameter `W`; ports `clk`, `reset`, `inc`, `cnt`) for `redirect_cnt`. It is reusable for other pipeline performance counters.
- Pending buffer, FSM and PC register live in the top module.

## Test plan
- Reset release, `imem_ready`=1, no stall:
  - One BOOT cycle with `fetch_valid`=0.
  - Then `Cur_PC` reads 0, 4, 8, 12 on successive cycles.
- `PcSel`=1, `BrPC`=0x40 at `Cur_PC`=0x10:
  - Same cycle: `flush_ifid`=`flush_idex`=1.
  - Next cycle: `Cur_PC`=0x40, `redirect_cnt`=1, `target_err`=0.
- `PcSel`=1 with `BrPC`=0x88, `imem_ready`=0 for 3 cycles:
  - First cycle: `flush_idex`=1.
  - `Cur_PC` holds its old value while `imem_ready`=0.
  - When `imem_ready`=1: `flush_ifid`=1, then `Cur_PC`=0x88.
  - A second `PcSel` arriving during the wait is ignored.
- `stall`=1 for 2 cycles at `Cur_PC`=0x20: PC holds at 0x20. Then `stall`=1 together with `PcSel`=1, `BrPC`=0x0: `Cur_PC`=0 next cycle and both flushes are 1.
- `BrPC`=0x20A (bit 9 and bit 1 set, `PC_W`=9): `Cur_PC`=0x008 next cycle and `target_err`=1, remaining 1 until reset. Running from `Cur_PC`=0x1FC without a redirect wraps to 0x000.
- 70000 redirects with `CNT_W`=16: `redirect_cnt` stops at 0xFFFF. Asserting `reset` low mid-PEND clears all outputs immediately.

Source files
------------

// File: rtl/pc_redirect_pkg.sv
// rtl/pc_redirect_pkg.sv - shared types and constants for the fetch-side PC redirect controller
package pc_redirect_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } redir_state_e;

  localparam int PC_INCR = 4;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating event counter, reusable for pipeline performance counters
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (inc && !(&cnt)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pc_redirect_ctrl.sv
// rtl/pc_redirect_ctrl.sv - program counter owner: advances fetch, applies EX-stage redirects,
// buffers a redirect that lands mid-fetch and squashes wrong-path IF/ID and ID/EX contents
module pc_redirect_ctrl
  import pc_redirect_pkg::*;
#(
  parameter int              PC_W     = 9,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int              CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             PcSel,
  input  logic [31:0]      BrPC,
  input  logic             stall,
  input  logic             imem_ready,
  output logic [PC_W-1:0]  Cur_PC,
  output logic             fetch_valid,
  output logic             flush_ifid,
  output logic             flush_idex,
  output logic             target_err,
  output logic [CNT_W-1:0] redirect_cnt
);

  redir_state_e    state;
  logic [PC_W-1:0] pend_tgt;
  logic [PC_W-1:0] tgt;
  logic            tgt_bad;
  logic            accept;

  assign tgt     = {BrPC[PC_W-1:2], 2'b00};
  assign tgt_bad = (BrPC[1:0] != 2'b00) || ((BrPC >> PC_W) != 32'd0);

  // Redirects are only taken in RUN; in PEND the EX stage has already been squashed.
  assign accept     = (state == RUN) && PcSel;
  assign flush_idex = accept;
  assign flush_ifid = (accept && imem_ready) || ((state == PEND) && imem_ready);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= BOOT;
      Cur_PC      <= RESET_PC;
      pend_tgt    <= '0;
      fetch_valid <= 1'b0;
      target_err  <= 1'b0;
    end else begin
      case (state)
        BOOT: begin
          state       <= RUN;
          fetch_valid <= 1'b1;
        end
        RUN: begin
          if (PcSel) begin
            if (tgt_bad) begin
              target_err <= 1'b1;
            end
            // The in-flight address must stay stable until imem completes it.
            if (imem_ready) begin
              Cur_PC <= tgt;
            end else begin
              pend_tgt <= tgt;
              state    <= PEND;
            end
          end else if (imem_ready && !stall) begin
            Cur_PC <= Cur_PC + PC_W'(PC_INCR);
          end
        end
        PEND: begin
          if (imem_ready) begin
            Cur_PC <= pend_tgt;
            state  <= RUN;
          end
        end
        default: begin
          state       <= BOOT;
          fetch_valid <= 1'b0;
        end
      endcase
    end
  end

  sat_counter #(
    .W(CNT_W)
  ) u_redirect_cnt (
    .clk  (clk),
    .reset(reset),
    .inc  (accept),
    .cnt  (redirect_cnt)
  );

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// tb/tb_pc_redirect_ctrl.sv - directed self-checking bench for pc_redirect_ctrl
module tb_pc_redirect_ctrl;

  localparam int PC_W  = 9;
  localparam int CNT_W = 16;

  logic             clk;
  logic             reset;
  logic             PcSel;
  logic [31:0]      BrPC;
  logic             stall;
  logic             imem_ready;
  logic [PC_W-1:0]  Cur_PC;
  logic             fetch_valid;
  logic             flush_ifid;
  logic             flush_idex;
  logic             target_err;
  logic [CNT_W-1:0] redirect_cnt;

  int passed = 0;
  int total  = 0;

  pc_redirect_ctrl #(
    .PC_W    (PC_W),
    .RESET_PC('0),
    .CNT_W   (CNT_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .PcSel       (PcSel),
    .BrPC        (BrPC),
    .stall       (stall),
    .imem_ready  (imem_ready),
    .Cur_PC      (Cur_PC),
    .fetch_valid (fetch_valid),
    .flush_ifid  (flush_ifid),
    .flush_idex  (flush_idex),
    .target_err  (target_err),
    .redirect_cnt(redirect_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_reset(input string tag);
    check({tag, " Cur_PC"},       32'(Cur_PC), 32'h0);
    check({tag, " fetch_valid"},  32'(fetch_valid), 32'h0);
    check({tag, " flush_ifid"},   32'(flush_ifid), 32'h0);
    check({tag, " flush_idex"},   32'(flush_idex), 32'h0);
    check({tag, " target_err"},   32'(target_err), 32'h0);
    check({tag, " redirect_cnt"}, 32'(redirect_cnt), 32'h0);
  endtask

  initial begin
    reset      = 1'b0;
    PcSel      = 1'b0;
    BrPC       = 32'h0;
    stall      = 1'b0;
    imem_ready = 1'b1;
    tick();
    tick();
    check_all_reset("reset");

    // BOOT cycle: no fetch and no flushes even with a redirect request present
    reset = 1'b1;
    #1;
    check("boot fetch_valid", 32'(fetch_valid), 32'h0);
    PcSel = 1'b1;
    BrPC  = 32'h40;
    #1;
    check("boot flush_ifid", 32'(flush_ifid), 32'h0);
    check("boot flush_idex", 32'(flush_idex), 32'h0);
    PcSel = 1'b0;
    tick();
    check("first fetch_valid", 32'(fetch_valid), 32'h1);
    check("first Cur_PC", 32'(Cur_PC), 32'h0);
    check("run flush_ifid idle", 32'(flush_ifid), 32'h0);
    tick();
    check("seq Cur_PC 4", 32'(Cur_PC), 32'h4);
    tick();
    check("seq Cur_PC 8", 32'(Cur_PC), 32'h8);
    tick();
    check("seq Cur_PC 12", 32'(Cur_PC), 32'hC);
    tick();
    check("seq Cur_PC 0x10", 32'(Cur_PC), 32'h10);

    // Redirect with imem ready
    PcSel = 1'b1;
    BrPC  = 32'h40;
    #1;
    check("redir flush_ifid", 32'(flush_ifid), 32'h1);
    check("redir flush_idex", 32'(flush_idex), 32'h1);
    tick();
    PcSel = 1'b0;
    check("redir Cur_PC", 32'(Cur_PC), 32'h40);
    check("redir cnt", 32'(redirect_cnt), 32'h1);
    check("redir target_err", 32'(target_err), 32'h0);

    // Redirect while imem busy: goes through PEND
    PcSel      = 1'b1;
    BrPC       = 32'h88;
    imem_ready = 1'b0;
    #1;
    check("pend flush_idex", 32'(flush_idex), 32'h1);
    check("pend flush_ifid", 32'(flush_ifid), 32'h0);
    tick();
    BrPC = 32'h100;
    #1;
    check("pend hold Cur_PC 1", 32'(Cur_PC), 32'h40);
    check("pend ignore flush_idex", 32'(flush_idex), 32'h0);
    check("pend wait flush_ifid", 32'(flush_ifid), 32'h0);
    check("pend cnt", 32'(redirect_cnt), 32'h2);
    tick();
    check("pend hold Cur_PC 2", 32'(Cur_PC), 32'h40);
    PcSel      = 1'b0;
    imem_ready = 1'b1;
    #1;
    check("pend release flush_ifid", 32'(flush_ifid), 32'h1);
    check("pend release flush_idex", 32'(flush_idex), 32'h0);
    tick();
    check("pend Cur_PC tgt", 32'(Cur_PC), 32'h88);
    check("pend cnt after", 32'(redirect_cnt), 32'h2);

    // Stall hold at 0x20, then stall together with redirect
    PcSel = 1'b1;
    BrPC  = 32'h20;
    tick();
    PcSel = 1'b0;
    check("to 0x20", 32'(Cur_PC), 32'h20);
    stall = 1'b1;
    tick();
    check("stall hold 1", 32'(Cur_PC), 32'h20);
    check("stall fetch_valid", 32'(fetch_valid), 32'h1);
    tick();
    check("stall hold 2", 32'(Cur_PC), 32'h20);
    PcSel = 1'b1;
    BrPC  = 32'h0;
    #1;
    check("stall+redir flush_ifid", 32'(flush_ifid), 32'h1);
    check("stall+redir flush_idex", 32'(flush_idex), 32'h1);
    tick();
    check("stall+redir Cur_PC", 32'(Cur_PC), 32'h0);
    check("stall+redir cnt", 32'(redirect_cnt), 32'h4);
    stall = 1'b0;

    // Misaligned and out-of-range target
    BrPC = 32'h20A;
    tick();
    check("bad tgt Cur_PC", 32'(Cur_PC), 32'h8);
    check("bad tgt target_err", 32'(target_err), 32'h1);
    BrPC = 32'h1FC;
    tick();
    PcSel = 1'b0;
    check("to 0x1FC", 32'(Cur_PC), 32'h1FC);
    check("sticky target_err", 32'(target_err), 32'h1);
    tick();
    check("wrap Cur_PC", 32'(Cur_PC), 32'h0);
    check("cnt before sat", 32'(redirect_cnt), 32'h6);

    // Saturation of the redirect counter
    PcSel = 1'b1;
    BrPC  = 32'h40;
    for (int i = 0; i < 70000; i++) begin
      tick();
    end
    check("cnt saturated", 32'(redirect_cnt), 32'hFFFF);
    tick();
    check("cnt stays saturated", 32'(redirect_cnt), 32'hFFFF);

    // Reset asserted mid-PEND discards the pending target
    BrPC       = 32'h80;
    imem_ready = 1'b0;
    tick();
    PcSel = 1'b0;
    check("pre-reset pend Cur_PC", 32'(Cur_PC), 32'h40);
    imem_ready = 1'b1;
    #1;
    reset = 1'b0;
    #1;
    check_all_reset("midpend reset");
    tick();
    reset = 1'b1;
    tick();
    check("post-reset fetch_valid", 32'(fetch_valid), 32'h1);
    check("post-reset Cur_PC", 32'(Cur_PC), 32'h0);
    tick();
    check("pending discarded", 32'(Cur_PC), 32'h4);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
